fp_normalize_pack: RTL and testbench

FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

---
 rtl/fp_normalize_pack.sv | 175 +++++++++++++++++
 tb/tb_fp_normalize_pack.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack
// Takes the raw result fields of a single-precision add/sub datapath
// (sign, larger-operand biased exponent, 28-bit sum with carry, hidden bit,
// fraction and guard/round/sticky). It normalizes the sum one bit per cycle,
// rounds to nearest-even and packs an IEEE-754 single result with overflow and
// zero flags.
//
// Ports
//   clk          single clock, rising edge
//   rstn         asynchronous active-low reset
//   in_valid     upstream fields valid
//   in_ready     block can accept (IDLE only)
//   in_sign      result sign
//   in_exp       biased exponent of the larger aligned operand
//   in_mant      {carry, hidden, fraction[22:0], guard, round, sticky}
//   out_valid    packed result valid
//   out_ready    downstream accepts
//   out_num      IEEE-754 single result
//   out_overflow result saturated to infinity
//   out_zero     result is exact zero
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// NORM  | one normalization step per cycle (zero / carry / done / subnormal / left shift)
// ROUND | round-to-nearest-even, renormalize on carry-out, saturate, pack
// DONE  | out_valid high, result held until out_ready
module fp_normalize_pack (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [7:0]  in_exp,
   input  logic [27:0] in_mant,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_num,
   output logic        out_overflow,
   output logic        out_zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_r, state_nxt;
   logic        sign_r, sign_nxt;
   logic [9:0]  exp_r, exp_nxt;
   logic [27:0] mant_r, mant_nxt;
   logic [31:0] num_r, num_nxt;
   logic        ovf_r, ovf_nxt;
   logic        zero_r, zero_nxt;

   logic        round_inc;
   logic [24:0] sig_sum;
   logic [23:0] sig_fin;
   logic [9:0]  exp_fin;

   // Rounding datapath; only consumed in ROUND.
   always_comb begin
      round_inc = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
      sig_sum   = {1'b0, mant_r[26:3]} + {24'd0, round_inc};
      if (sig_sum[24]) begin
         sig_fin = sig_sum[24:1];
         exp_fin = exp_r + 10'd1;
      end else begin
         sig_fin = sig_sum[23:0];
         exp_fin = exp_r;
      end
      // A subnormal whose significand reaches the hidden bit (by rounding or
      // from an input already normalized at exponent 0) encodes as exponent 1.
      if ((exp_fin == 10'd0) && sig_fin[23]) begin
         exp_fin = 10'd1;
      end
   end

   always_comb begin
      state_nxt = state_r;
      sign_nxt  = sign_r;
      exp_nxt   = exp_r;
      mant_nxt  = mant_r;
      num_nxt   = num_r;
      ovf_nxt   = ovf_r;
      zero_nxt  = zero_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               sign_nxt  = in_sign;
               exp_nxt   = {2'b00, in_exp};
               mant_nxt  = in_mant;
               state_nxt = NORM;
            end
         end
         NORM: begin
            if (exp_r == 10'd255) begin
               // Infinite/NaN operand exponent: bypass normalization.
               num_nxt   = {sign_r, 8'hFF, 23'd0};
               ovf_nxt   = 1'b1;
               zero_nxt  = 1'b0;
               state_nxt = DONE;
            end else if (mant_r == 28'd0) begin
               num_nxt   = 32'd0;
               ovf_nxt   = 1'b0;
               zero_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (mant_r[27]) begin
               mant_nxt  = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
               exp_nxt   = exp_r + 10'd1;
               state_nxt = ROUND;
            end else if (mant_r[26]) begin
               state_nxt = ROUND;
            end else if (exp_r <= 10'd1) begin
               exp_nxt   = 10'd0;
               state_nxt = ROUND;
            end else begin
               mant_nxt  = {mant_r[26:0], 1'b0};
               exp_nxt   = exp_r - 10'd1;
            end
         end
         ROUND: begin
            zero_nxt = 1'b0;
            if (exp_fin >= 10'd255) begin
               num_nxt = {sign_r, 8'hFF, 23'd0};
               ovf_nxt = 1'b1;
            end else begin
               num_nxt = {sign_r, exp_fin[7:0], sig_fin[22:0]};
               ovf_nxt = 1'b0;
            end
            state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sign_r <= 1'b0;
         exp_r  <= 10'd0;
         mant_r <= 28'd0;
         num_r  <= 32'd0;
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
      end else begin
         sign_r <= sign_nxt;
         exp_r  <= exp_nxt;
         mant_r <= mant_nxt;
         num_r  <= num_nxt;
         ovf_r  <= ovf_nxt;
         zero_r <= zero_nxt;
      end
   end

   assign in_ready     = (state_r == IDLE);
   assign out_valid    = (state_r == DONE);
   assign out_num      = num_r;
   assign out_overflow = ovf_r;
   assign out_zero     = zero_r;

endmodule

// File: tb/tb_fp_normalize_pack.sv
module tb_fp_normalize_pack;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_num;
   logic        out_overflow;
   logic        out_zero;

   int checks;
   int errors;

   fp_normalize_pack dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_exp       (in_exp),
      .in_mant      (in_mant),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_num      (out_num),
      .out_overflow (out_overflow),
      .out_zero     (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one operand, waits for the accept edge and then for out_valid.
   // lat counts the accept edge as 1; returns 99 if out_valid never rises.
   // Leaves the DUT in DONE (out_ready low) unless it timed out.
   task automatic start_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                           output int lat);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = 99;
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_num !== 32'h0) begin errors++; $display("FAIL reset_out_num got %h want 00000000", out_num); end
      checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", out_overflow); end
      checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", out_zero); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_normalized();
      int lat;
      start_op(1'b0, 8'd127, 28'h4000000, lat);
      checks++; if (out_num !== 32'h3F800000) begin errors++; $display("FAIL one_num got %h want 3f800000", out_num); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL one_latency got %0d want 3", lat); end
      checks++; if (out_overflow !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL one_flags got ovf %b zero %b want 0 0", out_overflow, out_zero); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
      finish_op();
   endtask

   task automatic test_carry();
      int lat;
      start_op(1'b0, 8'd127, 28'hC000000, lat);
      checks++; if (out_num !== 32'h40400000) begin errors++; $display("FAIL carry_num got %h want 40400000", out_num); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL carry_latency got %0d want 3", lat); end
      finish_op();
   endtask

   task automatic test_left_shift();
      int lat;
      start_op(1'b0, 8'd130, 28'h0800000, lat);
      checks++; if (out_num !== 32'h3F800000) begin errors++; $display("FAIL lshift_num got %h want 3f800000", out_num); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL lshift_latency got %0d want 6", lat); end
      finish_op();
      start_op(1'b1, 8'd100, 28'h0, lat);
      checks++; if (out_num !== 32'h0) begin errors++; $display("FAIL zero_num got %h want 00000000", out_num); end
      checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL zero_flag got %b want 1", out_zero); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency got %0d want 2", lat); end
      finish_op();
   endtask

   task automatic test_round();
      int lat;
      start_op(1'b0, 8'd127, 28'h7FFFFFC, lat);
      checks++; if (out_num !== 32'h40000000) begin errors++; $display("FAIL round_up_num got %h want 40000000", out_num); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL round_up_latency got %0d want 3", lat); end
      finish_op();
      start_op(1'b0, 8'd127, 28'h7FFFFFB, lat);
      checks++; if (out_num !== 32'h3FFFFFFF) begin errors++; $display("FAIL round_down_num got %h want 3fffffff", out_num); end
      finish_op();
      start_op(1'b0, 8'd127, 28'h4000004, lat);
      checks++; if (out_num !== 32'h3F800000) begin errors++; $display("FAIL tie_even_num got %h want 3f800000", out_num); end
      finish_op();
      start_op(1'b0, 8'd127, 28'h400000C, lat);
      checks++; if (out_num !== 32'h3F800002) begin errors++; $display("FAIL tie_odd_num got %h want 3f800002", out_num); end
      finish_op();
   endtask

   task automatic test_subnormal();
      int lat;
      start_op(1'b0, 8'd1, 28'h2000000, lat);
      checks++; if (out_num !== 32'h00400000) begin errors++; $display("FAIL subnorm_num got %h want 00400000", out_num); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL subnorm_latency got %0d want 3", lat); end
      finish_op();
      start_op(1'b0, 8'd3, 28'h1000000, lat);
      checks++; if (out_num !== 32'h00800000) begin errors++; $display("FAIL min_normal_num got %h want 00800000", out_num); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL min_normal_latency got %0d want 5", lat); end
      finish_op();
   endtask

   task automatic test_overflow_stall();
      int lat;
      start_op(1'b0, 8'd254, 28'h8000000, lat);
      checks++; if (out_num !== 32'h7F800000) begin errors++; $display("FAIL ovf_num got %h want 7f800000", out_num); end
      checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", out_overflow); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL ovf_latency got %0d want 3", lat); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_num !== 32'h7F800000) begin
            errors++; $display("FAIL stall_hold cycle %0d got valid %b num %h want 1 7f800000", i, out_valid, out_num);
         end
      end
      finish_op();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL after_transfer got valid %b ready %b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_inf_input();
      int lat;
      start_op(1'b1, 8'd255, 28'h4123450, lat);
      checks++; if (out_num !== 32'hFF800000) begin errors++; $display("FAIL inf_num got %h want ff800000", out_num); end
      checks++; if (out_overflow !== 1'b1 || out_zero !== 1'b0) begin errors++; $display("FAIL inf_flags got ovf %b zero %b want 1 0", out_overflow, out_zero); end
      finish_op();
   endtask

   task automatic test_back_to_back();
      int lat;
      // Keep in_valid high through the transfer cycle: the next operand must
      // only be taken once the block is back in IDLE.
      start_op(1'b0, 8'd127, 28'h4000000, lat);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'd127;
      in_mant  = 28'hC000000;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready got %b want 0", in_ready); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready %b valid %b want 1 0", in_ready, out_valid); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_norm_ready got %b want 0", in_ready); end
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (out_num !== 32'h40400000 || lat !== 3) begin errors++; $display("FAIL b2b_second got %h lat %0d want 40400000 lat 3", out_num, lat); end
      finish_op();
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'd137;
      in_mant  = 28'h0010000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_async got ready %b valid %b want 1 0", in_ready, out_valid); end
      @(negedge clk);
      rstn = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_output got %0d valid cycles want 0", seen); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", in_ready); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 8'd0;
      in_mant   = 28'd0;
      out_ready = 1'b0;
      test_reset();
      test_normalized();
      test_carry();
      test_left_shift();
      test_round();
      test_subnormal();
      test_overflow_stall();
      test_inf_input();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
